ps2_scan_decoder: RTL and testbench
===================================

# ps2_scan_decoder

Downstream consumer of the PS/2 keyboard receiver's byte FIFO. Pops scan-code bytes over the receiver's `ready`/`read_n` handshake and tracks Set-2 prefixes (`E0` extended, `F0` break) with a small state machine. Maintains the currently held key, a BCD count of distinct key presses, an optional ASCII translation and a sticky FIFO-overflow flag. These outputs drive the seven-segment display logic in place of the raw latched byte.

## Interface
Parameters: none.

Ports:
- `clk` input 1: system clock; all logic on posedge.
- `rst_n` input 1: reset; one clock; reset is asynchronous and active-low.
- `ready` input 1: receiver FIFO non-empty; `data` is valid while high.
- `data` input 8: FIFO head byte.
- `overflow` input 1: receiver FIFO overflow indication.
- `read_n` output 1: active-low pop strobe to receiver, one cycle wide.
- `key_code` output 8: last make code accepted (non-prefix byte).
- `key_ext` output 1: `key_code` was preceded by `E0`.
- `key_down` output 1: the key in `key_code`/`key_ext` is currently held.
- `ascii` output 8: ASCII of held key, `8'h00` if none/unmapped.
- `press_cnt` output 8: two BCD digits [7:4] tens, [3:0] units, count of new key presses.
- `ovf_sticky` output 1: set once `overflow` seen high.

## Operation
- Reset values: `read_n`=1, `key_code`=8'h00, `key_ext`=0, `key_down`=0, `press_cnt`=8'h00, `ovf_sticky`=0, state=IDLE. Reset mid-sequence discards any pending prefix.
- Pop rule: at a posedge where `ready`=1 and `read_n`=1, the byte is consumed: `read_n`<=0 and the byte is processed at that same edge. At the next edge `read_n`<=1 unconditionally, and `ready`/`data` are not sampled. At most one byte every 2 cycles.
- States: IDLE, EXT, BREAK, EXT_BREAK.
- Byte `E0` in any state -> EXT. A pending break is dropped.
- Byte `F0`: IDLE or BREAK -> BREAK; EXT or EXT_BREAK -> EXT_BREAK.
- Bytes `00` and `FF` (keyboard error codes): ignored; state unchanged.
- Other byte `c` in IDLE/EXT (make), with `x` = (state==EXT):
  - If `key_down`=1, `key_code`==`c` and `key_ext`==`x`: typematic repeat, no change.
  - Otherwise `key_code`<=`c`, `key_ext`<=`x`, `key_down`<=1, `press_cnt` increments in BCD.
  - Next state: IDLE.
- Other byte `c` in BREAK/EXT_BREAK (break), with `x` = (state==EXT_BREAK):
  - If it matches `key_code`/`key_ext`: `key_down`<=0; `key_code` is retained.
  - Else ignored.
  - Next state: IDLE.
- BCD increment: units 9 -> 0 with carry into tens; `8'h99` -> `8'h00`.
- `ovf_sticky` <= 1 at any edge with `overflow`=1; cleared only by `rst_n`.
- `ascii` is combinational from registered `key_code`/`key_ext`/`key_down`.

## Timing
- Pop strobe: `read_n` low for exactly one cycle following each consuming edge.
- Output latency: outputs update at the same edge that consumes the byte, i.e. visible 0 cycles after the edge, concurrent with `read_n` low.
- Back-to-back FIFO bytes: consuming edges N, N+2, N+4, …
- `ready` deasserting during the `read_n`-low cycle is legal; no effect.

## Configuration
- `PS2_DEC_ASCII_EN` defined:
  - `ascii` = lowercase ASCII of `key_code` when `key_down`=1 and `key_ext`=0, for: letters a–z (Set-2 codes, e.g. `1C`->`61`), digits 0–9 on the main row (`45`->`30`, `16`->`31` …), `29`->`20` (space), `5A`->`0D` (enter).
  - Otherwise `8'h00`.
- Undefined: `ascii` tied to `8'h00`; no lookup logic synthesised.

## Test plan
- Reset: hold `rst_n`=0 with `ready`=1 -> `read_n`=1, all outputs zero, no pops. Release -> first pop at first posedge.
- Make/break: feed `1C`, `F0`, `1C`:
  - After the first byte: `key_code`=`1C`, `key_down`=1, `press_cnt`=`01`, `ascii`=`61` (macro on) / `00` (off).
  - After the final byte: `key_down`=0, `key_code`=`1C`, `ascii`=`00`.
- Typematic and extended: feed `1C`,`1C`,`1C` -> `press_cnt`=`01`. Then `E0`,`75` -> `key_code`=`75`, `key_ext`=1, `press_cnt`=`02`, `ascii`=`00`. Then `E0`,`F0`,`75` -> `key_down`=0.
- Handshake pacing: hold `ready`=1 for 3 queued bytes -> `read_n` low pulses exactly at cycles N+1, N+3, N+5, each one cycle wide.
- BCD wrap: 99 distinct make/break pairs -> `press_cnt`=`99`; one more -> `00`. Mismatched break (`F0`,`23` while `1C` held) -> `key_down` stays 1.
- Overflow/reset mid-prefix: pulse `overflow` one cycle -> `ovf_sticky`=1 persists. Feed `F0`, assert `rst_n`=0, release, feed `1C` -> treated as make, `press_cnt`=`01`, `ovf_sticky`=0.

Source files
------------

// File: rtl/ps2_scan_decoder.sv
// PS/2 Set-2 scan-code decoder: pops bytes from the receiver FIFO and tracks the held key and press count.
// Define PS2_DEC_ASCII_EN to build the lowercase ASCII lookup; otherwise ascii is tied to zero.
module ps2_scan_decoder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ready,
    input  logic [7:0] data,
    input  logic       overflow,
    output logic       read_n,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_down,
    output logic [7:0] ascii,
    output logic [7:0] press_cnt,
    output logic       ovf_sticky
);

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BREAK,
        EXT_BREAK
    } state_t;

    state_t state;
    logic   make_ext;
    logic   break_ext;
    logic   consume;

    assign make_ext  = (state == EXT);
    assign break_ext = (state == EXT_BREAK);
    assign consume   = read_n && ready;

    // Two-digit BCD increment, wrapping 99 -> 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [3:0] units;
        logic [3:0] tens;
        units = v[3:0];
        tens  = v[7:4];
        if (units == 4'd9) begin
            units = 4'd0;
            tens  = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
        end else begin
            units = units + 4'd1;
        end
        return {tens, units};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            read_n     <= 1'b1;
            key_code   <= 8'h00;
            key_ext    <= 1'b0;
            key_down   <= 1'b0;
            press_cnt  <= 8'h00;
            ovf_sticky <= 1'b0;
        end else begin
            if (overflow) begin
                ovf_sticky <= 1'b1;
            end
            if (consume) begin
                read_n <= 1'b0;
                case (data)
                    8'hE0: state <= EXT;
                    8'hF0: state <= (make_ext || break_ext) ? EXT_BREAK : BREAK;
                    8'h00, 8'hFF: begin
                        state <= state;
                    end
                    default: begin
                        if (state == IDLE || state == EXT) begin
                            // A held key re-sent unchanged is typematic repeat, not a new press.
                            if (!(key_down && key_code == data && key_ext == make_ext)) begin
                                key_code  <= data;
                                key_ext   <= make_ext;
                                key_down  <= 1'b1;
                                press_cnt <= bcd_inc(press_cnt);
                            end
                        end else if (key_code == data && key_ext == break_ext) begin
                            key_down <= 1'b0;
                        end
                        state <= IDLE;
                    end
                endcase
            end else begin
                read_n <= 1'b1;
            end
        end
    end

`ifdef PS2_DEC_ASCII_EN
    // Lowercase letters, main-row digits, space and enter; extended keys are unmapped.
    always_comb begin
        ascii = 8'h00;
        if (key_down && !key_ext) begin
            case (key_code)
                8'h1C: ascii = 8'h61;
                8'h32: ascii = 8'h62;
                8'h21: ascii = 8'h63;
                8'h23: ascii = 8'h64;
                8'h24: ascii = 8'h65;
                8'h2B: ascii = 8'h66;
                8'h34: ascii = 8'h67;
                8'h33: ascii = 8'h68;
                8'h43: ascii = 8'h69;
                8'h3B: ascii = 8'h6A;
                8'h42: ascii = 8'h6B;
                8'h4B: ascii = 8'h6C;
                8'h3A: ascii = 8'h6D;
                8'h31: ascii = 8'h6E;
                8'h44: ascii = 8'h6F;
                8'h4D: ascii = 8'h70;
                8'h15: ascii = 8'h71;
                8'h2D: ascii = 8'h72;
                8'h1B: ascii = 8'h73;
                8'h2C: ascii = 8'h74;
                8'h3C: ascii = 8'h75;
                8'h2A: ascii = 8'h76;
                8'h1D: ascii = 8'h77;
                8'h22: ascii = 8'h78;
                8'h35: ascii = 8'h79;
                8'h1A: ascii = 8'h7A;
                8'h45: ascii = 8'h30;
                8'h16: ascii = 8'h31;
                8'h1E: ascii = 8'h32;
                8'h26: ascii = 8'h33;
                8'h25: ascii = 8'h34;
                8'h2E: ascii = 8'h35;
                8'h36: ascii = 8'h36;
                8'h3D: ascii = 8'h37;
                8'h3E: ascii = 8'h38;
                8'h46: ascii = 8'h39;
                8'h29: ascii = 8'h20;
                8'h5A: ascii = 8'h0D;
                default: ascii = 8'h00;
            endcase
        end
    end
`else
    assign ascii = 8'h00;
`endif

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Scoreboard bench for ps2_scan_decoder: a FIFO model feeds bytes, a monitor checks each pop's outputs.
module tb_ps2_scan_decoder;

    logic       clk;
    logic       rst_n;
    logic       ready;
    logic [7:0] data;
    logic       overflow;
    logic       read_n;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_down;
    logic [7:0] ascii;
    logic [7:0] press_cnt;
    logic       ovf_sticky;

    ps2_scan_decoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ready      (ready),
        .data       (data),
        .overflow   (overflow),
        .read_n     (read_n),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .key_down   (key_down),
        .ascii      (ascii),
        .press_cnt  (press_cnt),
        .ovf_sticky (ovf_sticky)
    );

    typedef struct {
        logic [7:0] kc;
        logic       ke;
        logic       kd;
        logic [7:0] cnt;
        logic [7:0] asc;
        logic       ovf;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] stimq[$];
    int         pulses[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         rise_cyc = 0;
    logic       exp_ovf = 1'b0;
    logic       prev_low = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [7:0] mask_asc(input logic [7:0] a);
`ifdef PS2_DEC_ASCII_EN
        return a;
`else
        return (a == a) ? 8'h00 : 8'h00;
`endif
    endfunction

    function automatic logic [7:0] to_bcd(input int n);
        int m;
        m = n % 100;
        return {4'(m / 10), 4'(m % 10)};
    endfunction

    task automatic feed(input logic [7:0] b, input logic [7:0] kc, input logic ke,
                        input logic kd, input logic [7:0] cnt, input logic [7:0] asc);
        exp_t e;
        e.kc  = kc;
        e.ke  = ke;
        e.kd  = kd;
        e.cnt = cnt;
        e.asc = mask_asc(asc);
        e.ovf = exp_ovf;
        stimq.push_back(b);
        expq.push_back(e);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((stimq.size() != 0 || expq.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            bad++;
            total++;
            $display("FAIL idle_timeout: got %0d pending expected 0", expq.size());
            expq.delete();
            stimq.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Receiver FIFO model: removes the head byte when it sees the pop strobe.
    initial begin
        ready = 1'b0;
        data  = 8'h00;
        forever begin
            @(negedge clk);
            if (!read_n && stimq.size() != 0) void'(stimq.pop_front());
            if (!ready && stimq.size() != 0) rise_cyc = cyc;
            ready = (stimq.size() != 0);
            data  = (stimq.size() != 0) ? stimq[0] : 8'h00;
        end
    end

    // Monitor: every pop strobe presents the outputs for the byte just consumed.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && !read_n) begin
                pulses.push_back(cyc);
                chk("pulse_width", 32'(prev_low), 32'(0));
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pop: got pop expected none (cycle %0d)", cyc);
                end else begin
                    e = expq.pop_front();
                    chk("key_code", 32'(key_code), 32'(e.kc));
                    chk("key_ext", 32'(key_ext), 32'(e.ke));
                    chk("key_down", 32'(key_down), 32'(e.kd));
                    chk("press_cnt", 32'(press_cnt), 32'(e.cnt));
                    chk("ascii", 32'(ascii), 32'(e.asc));
                    chk("ovf_sticky", 32'(ovf_sticky), 32'(e.ovf));
                end
            end
            prev_low = rst_n && !read_n;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        overflow = 1'b0;

        // Reset held with a byte waiting: nothing may be popped.
        repeat (2) @(negedge clk);
        feed(8'h1C, 8'h1C, 1'b0, 1'b1, 8'h01, 8'h61);
        repeat (3) begin
            @(negedge clk);
            chk("rst_read_n", 32'(read_n), 32'(1));
            chk("rst_outputs", {8'(key_code), 8'(press_cnt), 8'(ascii),
                5'(0), key_ext, key_down, ovf_sticky}, 32'(0));
            chk("rst_no_pop", 32'(stimq.size()), 32'(1));
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_pop", 32'(read_n), 32'(0));
        wait_idle();

        // Break of the held key.
        feed(8'hF0, 8'h1C, 1'b0, 1'b1, 8'h01, 8'h61);
        feed(8'h1C, 8'h1C, 1'b0, 1'b0, 8'h01, 8'h00);
        wait_idle();

        // Typematic repeats then an extended make/break.
        do_reset();
        feed(8'h1C, 8'h1C, 1'b0, 1'b1, 8'h01, 8'h61);
        feed(8'h1C, 8'h1C, 1'b0, 1'b1, 8'h01, 8'h61);
        feed(8'h1C, 8'h1C, 1'b0, 1'b1, 8'h01, 8'h61);
        feed(8'hE0, 8'h1C, 1'b0, 1'b1, 8'h01, 8'h61);
        feed(8'h75, 8'h75, 1'b1, 1'b1, 8'h02, 8'h00);
        feed(8'hE0, 8'h75, 1'b1, 1'b1, 8'h02, 8'h00);
        feed(8'hF0, 8'h75, 1'b1, 1'b1, 8'h02, 8'h00);
        feed(8'h75, 8'h75, 1'b1, 1'b0, 8'h02, 8'h00);
        wait_idle();

        // Three queued bytes: strobes at rise+1, +3, +5.
        pulses.delete();
        feed(8'h16, 8'h16, 1'b0, 1'b1, 8'h03, 8'h31);
        feed(8'h16, 8'h16, 1'b0, 1'b1, 8'h03, 8'h31);
        feed(8'h1E, 8'h1E, 1'b0, 1'b1, 8'h04, 8'h32);
        wait_idle();
        chk("pace_count", 32'(pulses.size()), 32'(3));
        for (int i = 0; i < 3 && i < pulses.size(); i++)
            chk("pace_cycle", 32'(pulses[i]), 32'(rise_cyc + 1 + 2 * i));

        // Mismatched break, error codes, and a break prefix cancelled by E0.
        feed(8'h1C, 8'h1C, 1'b0, 1'b1, 8'h05, 8'h61);
        feed(8'hF0, 8'h1C, 1'b0, 1'b1, 8'h05, 8'h61);
        feed(8'h23, 8'h1C, 1'b0, 1'b1, 8'h05, 8'h61);
        feed(8'hFF, 8'h1C, 1'b0, 1'b1, 8'h05, 8'h61);
        feed(8'h00, 8'h1C, 1'b0, 1'b1, 8'h05, 8'h61);
        feed(8'hF0, 8'h1C, 1'b0, 1'b1, 8'h05, 8'h61);
        feed(8'hE0, 8'h1C, 1'b0, 1'b1, 8'h05, 8'h61);
        feed(8'h1C, 8'h1C, 1'b1, 1'b1, 8'h06, 8'h00);
        wait_idle();

        // BCD count through 99 and wrap to 00.
        do_reset();
        for (int i = 1; i <= 100; i++) begin
            feed(8'h1C, 8'h1C, 1'b0, 1'b1, to_bcd(i), 8'h61);
            feed(8'hF0, 8'h1C, 1'b0, 1'b1, to_bcd(i), 8'h61);
            feed(8'h1C, 8'h1C, 1'b0, 1'b0, to_bcd(i), 8'h00);
            if (i == 99 || i == 100) wait_idle();
        end

        // Sticky overflow, then reset while a break prefix is pending.
        @(negedge clk);
        overflow = 1'b1;
        @(negedge clk);
        overflow = 1'b0;
        exp_ovf  = 1'b1;
        repeat (3) @(negedge clk);
        chk("ovf_sticky_hold", 32'(ovf_sticky), 32'(1));
        feed(8'hF0, 8'h1C, 1'b0, 1'b0, 8'h00, 8'h00);
        wait_idle();
        do_reset();
        exp_ovf = 1'b0;
        feed(8'h1C, 8'h1C, 1'b0, 1'b1, 8'h01, 8'h61);
        wait_idle();

        chk("leftover_expect", 32'(expq.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
